// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
// Holds the E-stage MDU operation encoding, the sequencer state enum,
// the default busy-cycle counts and small op-classification helpers.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the ops that launch a multi-cycle computation.
    function automatic logic is_start(input logic [3:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the multiply ops; selects the shorter latency.
    function automatic logic is_mult(input logic [3:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational 64-bit {hi,lo} result of an MDU op.
// Ports:
//   op      in  4   MDU operation (mdu_pkg encoding)
//   a, b    in  32  rs / rt operands
//   old_hi  in  32  currently committed HI (returned on divide by zero)
//   old_lo  in  32  currently committed LO (returned on divide by zero)
//   result  out 64  {hi,lo}; zero for ops that do not compute
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] old_hi,
    input  logic [31:0] old_lo,
    output logic [63:0] result
);

    logic        div_zero_s;
    logic        div_ovf_s;
    logic [31:0] bs_safe_s;
    logic [31:0] bu_safe_s;
    logic [63:0] prod_s_s;
    logic [63:0] prod_u_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;

    // Products, quotients and remainders for every op in parallel.
    always_comb begin
        div_zero_s = (b == 32'd0);
        div_ovf_s  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        // Dividing by 1 in the overflow case yields exactly the defined
        // answer (lo=0x80000000, hi=0) and keeps the divider well-formed.
        bs_safe_s  = (div_zero_s || div_ovf_s) ? 32'd1 : b;
        bu_safe_s  = div_zero_s ? 32'd1 : b;
        prod_s_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u_s   = {32'd0, a} * {32'd0, b};
        sq_s       = $signed(a) / $signed(bs_safe_s);
        sr_s       = $signed(a) % $signed(bs_safe_s);
        uq_s       = a / bu_safe_s;
        ur_s       = a % bu_safe_s;
    end

    // Select the result for the requested op.
    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:  result = prod_s_s;
            MD_MULTU: result = prod_u_s;
            MD_DIV: begin
                if (div_zero_s) begin
                    result = {old_hi, old_lo};
                end else begin
                    result = {sr_s, sq_s};
                end
            end
            MD_DIVU: begin
                if (div_zero_s) begin
                    result = {old_hi, old_lo};
                end else begin
                    result = {ur_s, uq_s};
                end
            end
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer in the E stage.
// Owns HI/LO, models fixed mult/div latency and raises stall_d while an
// MDU instruction in D would otherwise collide with an in-flight op.
// Ports:
//   clk        in  1   pipeline clock, rising edge
//   reset      in  1   asynchronous active-low reset
//   md_op_e    in  4   E-stage MDU op (mdu_pkg encoding)
//   a_e, b_e   in  32  forwarded rs / rt values
//   md_use_d   in  1   D-stage instruction is an MDU op
//   busy       out 1   mult/div in flight
//   stall_d    out 1   freeze F/D, bubble into E
//   rd_data_e  out 32  HI for MFHI, LO for MFLO, else 0
//   hi, lo     out 32  committed HI / LO
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op_e,
    input  logic [31:0] a_e,
    input  logic [31:0] b_e,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_d,
    output logic [31:0] rd_data_e,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t  state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic [31:0] pend_hi_r, pend_hi_nxt_s;
    logic [31:0] pend_lo_r, pend_lo_nxt_s;
    logic [31:0] hi_r, hi_nxt_s;
    logic [31:0] lo_r, lo_nxt_s;
    logic        busy_r;
    logic        start_s;
    logic [63:0] arith_s;

    mdu_arith u_arith (
        .op     (md_op_e),
        .a      (a_e),
        .b      (b_e),
        .old_hi (hi_r),
        .old_lo (lo_r),
        .result (arith_s)
    );

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        pend_hi_nxt_s = pend_hi_r;
        pend_lo_nxt_s = pend_lo_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        start_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (is_start(md_op_e)) begin
                    start_s       = 1'b1;
                    pend_hi_nxt_s = arith_s[63:32];
                    pend_lo_nxt_s = arith_s[31:0];
                    cnt_nxt_s     = is_mult(md_op_e) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    state_nxt_s   = ST_RUN;
                end else if (md_op_e == MD_MTHI) begin
                    hi_nxt_s = a_e;
                end else if (md_op_e == MD_MTLO) begin
                    lo_nxt_s = a_e;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Ops arriving here are protocol violations and are ignored.
                cnt_nxt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    hi_nxt_s    = pend_hi_r;
                    lo_nxt_s    = pend_lo_r;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, counter and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pend_hi_r <= pend_hi_nxt_s;
            pend_lo_r <= pend_lo_nxt_s;
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            busy_r    <= (state_nxt_s == ST_RUN);
        end
    end

    // Move-from read port sees committed values only.
    always_comb begin
        rd_data_e = 32'd0;
        case (md_op_e)
            MD_MFHI: rd_data_e = hi_r;
            MD_MFLO: rd_data_e = lo_r;
            default: rd_data_e = 32'd0;
        endcase
    end

    assign busy    = busy_r;
    assign stall_d = md_use_d & (busy_r | start_s);
    assign hi      = hi_r;
    assign lo      = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op_e;
    logic [31:0] a_e;
    logic [31:0] b_e;
    logic        md_use_d;
    logic        busy;
    logic        stall_d;
    logic [31:0] rd_data_e;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_op_e   (md_op_e),
        .a_e       (a_e),
        .b_e       (b_e),
        .md_use_d  (md_use_d),
        .busy      (busy),
        .stall_d   (stall_d),
        .rd_data_e (rd_data_e),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Start a new cycle: drive inputs after the falling edge, settle.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d);
        @(negedge clk);
        md_op_e  = op;
        a_e      = a;
        b_e      = b;
        md_use_d = use_d;
        #1;
    endtask

    // Launch an op in cycle 0, check busy/stall through cycle n, then
    // check release and the committed HI/LO in cycle n+1.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic use_d, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        drive(op, a, b, use_d);
        chk({tag, ".c0_stall"}, {31'd0, stall_d}, {31'd0, use_d});
        chk({tag, ".c0_busy"}, {31'd0, busy}, 32'd0);
        for (int k = 1; k <= n; k++) begin
            drive(MD_NONE, 32'd0, 32'd0, use_d);
            chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
            chk({tag, ".stall"}, {31'd0, stall_d}, {31'd0, use_d});
        end
        drive(MD_NONE, 32'd0, 32'd0, use_d);
        chk({tag, ".done_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".done_stall"}, {31'd0, stall_d}, 32'd0);
        chk({tag, ".hi"}, hi, exp_hi);
        chk({tag, ".lo"}, lo, exp_lo);
    endtask

    initial begin
        reset    = 1'b0;
        md_op_e  = MD_NONE;
        a_e      = 32'd0;
        b_e      = 32'd0;
        md_use_d = 1'b1;
        #12;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.stall", {31'd0, stall_d}, 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        drive(MD_MFHI, 32'd0, 32'd0, 1'b0);
        chk("mfhi", rd_data_e, 32'hFFFF_FFFF);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        chk("rd_none", rd_data_e, 32'd0);

        run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", MD_DIVU, 32'd7, 32'd2, 1'b1, 10, 32'd1, 32'd3);

        drive(MD_MTHI, 32'h11, 32'd0, 1'b0);
        drive(MD_MTLO, 32'h22, 32'd0, 1'b0);
        chk("mthi.hi", hi, 32'h11);
        chk("mthi.lo_kept", lo, 32'd3);
        drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("mflo.22", rd_data_e, 32'h22);

        run_op("div0", MD_DIV, 32'd1234, 32'd0, 1'b1, 10, 32'h11, 32'h22);
        run_op("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'd0, 32'h8000_0000);

        drive(MD_MTLO, 32'hABCD, 32'd0, 1'b0);
        drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("mflo.abcd", rd_data_e, 32'h0000_ABCD);

        // Reset arrives in cycle 3 of a DIV.
        drive(MD_DIV, 32'd100, 32'd7, 1'b1);
        drive(MD_NONE, 32'd0, 32'd0, 1'b1);
        drive(MD_NONE, 32'd0, 32'd0, 1'b1);
        chk("pre_rst.busy", {31'd0, busy}, 32'd1);
        drive(MD_NONE, 32'd0, 32'd0, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.stall", {31'd0, stall_d}, 32'd0);
        chk("midrst.hi", hi, 32'd0);
        chk("midrst.lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult2", MD_MULT, 32'd6, 32'd7, 1'b1, 5, 32'd0, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer for the five-stage MIPS pipeline, sitting in the E stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO operations from the decoder, owns the HI/LO registers, and models the fixed multi-cycle latency. While an operation is in flight it drives the stall that the hazard unit merges into its D-stage freeze.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- md_op_e  in  4  E-stage MDU operation, encoded per mdu_pkg; NONE=0
- a_e  in  32  forwarded rs value in E
- b_e  in  32  forwarded rt value in E
- md_use_d  in  1  decoder flag: the D-stage instruction is any MDU op
- busy  out  1  high while a mult/div is in flight
- stall_d  out  1  freeze F/D, bubble into E
- rd_data_e  out  32  MFHI→HI, MFLO→LO, otherwise 0
- hi  out  32  committed HI
- lo  out  32  committed LO

## Operation
- States: IDLE, RUN. Internal: cnt (4 bits), pend_hi, pend_lo (32 bits each).
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, hi=lo=0, pend=0, busy=0, stall_d=0.
- In IDLE, start = md_op_e ∈ {MULT,MULTU,DIV,DIVU}. On a start edge:
  - latch the result into pend_hi/pend_lo;
  - cnt = MULT_CYCLES or DIV_CYCLES;
  - move to RUN.
- In RUN, each edge decrements cnt. On the edge where cnt==1: hi=pend_hi, lo=pend_lo, move to IDLE.
- MTHI/MTLO in IDLE: write a_e to hi or lo at the next edge.
- MDU ops while in RUN (any op other than NONE) are a protocol violation. They are ignored, and stall_d guarantees they never arrive.
- busy = (state==RUN).
- stall_d = md_use_d & (busy | start). This covers both the start cycle and every RUN cycle.
- rd_data_e is combinational from committed hi/lo. MFHI/MFLO never see pend values, because stall_d holds them in D until commit.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (b_e==0): takes full DIV_CYCLES, then commits the old hi/lo unchanged.

## Timing
- Start op present in cycle 0; stall_d=1 in cycle 0 if md_use_d.
- busy=1 in cycles 1..N (N = MULT_CYCLES or DIV_CYCLES).
- New hi/lo visible from cycle N+1; busy=0 and the stall releases in cycle N+1.
- Back-to-back: a second MDU op in D stalls through cycle N, enters E in cycle N+1, and may start there.
- MTHI/MTLO: hi/lo updated at the end of the cycle, so an MFHI in the following cycle reads the new value.
- Non-MDU instructions flow freely during RUN; stall_d depends on md_use_d only.
- Reset mid-RUN aborts immediately: pend is discarded and hi/lo=0.

## Structure
- mdu_pkg holds:
  - md_op encoding: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO;
  - state enum;
  - default cycle constants.
- Sub-module mdu_arith: purely combinational 64-bit result of op/a/b, including the divide-by-zero and overflow rules. mdu_ctrl holds only the FSM, counter and registers.
- Decoder extension (adds md_op and md_use outputs) is a separate change.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 → busy cycles 1–5; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7, b=2 → busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- DIV by zero with prior hi=0x11, lo=0x22 → 10 busy cycles, hi/lo still 0x11/0x22. DIV 0x80000000/-1 → lo=0x80000000, hi=0.
- MULT start with md_use_d=1 held → stall_d=1 in cycles 0–5, 0 in cycle 6. With md_use_d=0, stall_d=0 throughout while busy=1.
- MTLO a=0xABCD then MFLO next cycle → rd_data_e=0xABCD. MTHI does not alter lo.
- Assert reset in cycle 3 of a DIV → busy=0, hi=lo=0 immediately. After release, a new MULT completes normally in 5 cycles.
